// File: rtl/pulse_train_tx.sv
// Moore pulse-train transmitter: emits N high pulses of H' en-ticks separated by
// L' en-tick gaps, then a one-tick done, using a start/busy/done handshake.
module pulse_train_tx #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    output logic             out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    logic [LEN_W-1:0] phase_q, phase_d;
    logic [LEN_W-1:0] hlen_q, hlen_d;
    logic [LEN_W-1:0] llen_q, llen_d;
    logic             out_q, busy_q, done_q;

    // A zero-length phase request is stretched to one en-tick.
    function automatic logic [LEN_W-1:0] at_least_one(input logic [LEN_W-1:0] v);
        at_least_one = (v == LEN_ZERO) ? LEN_ONE : v;
    endfunction

    // Next-state and counter update, advancing only on enabled ticks.
    always_comb begin
        state_d  = state_q;
        pulses_d = pulses_q;
        phase_d  = phase_q;
        hlen_d   = hlen_q;
        llen_d   = llen_q;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        hlen_d = at_least_one(high_len);
                        llen_d = at_least_one(low_len);
                        if (count == CNT_ZERO) begin
                            state_d  = S_DONE;
                            pulses_d = CNT_ZERO;
                            phase_d  = LEN_ZERO;
                        end else begin
                            state_d  = S_HIGH;
                            pulses_d = count;
                            phase_d  = at_least_one(high_len);
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HIGH: begin
                    if (phase_q == LEN_ONE) begin
                        pulses_d = pulses_q - CNT_ONE;
                        if (pulses_q == CNT_ONE) begin
                            state_d = S_DONE;
                            phase_d = LEN_ZERO;
                        end else begin
                            state_d = S_LOW;
                            phase_d = llen_q;
                        end
                    end else begin
                        phase_d = phase_q - LEN_ONE;
                    end
                end
                S_LOW: begin
                    if (phase_q == LEN_ONE) begin
                        state_d = S_HIGH;
                        phase_d = hlen_q;
                    end else begin
                        phase_d = phase_q - LEN_ONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, counters and output flops; outputs track the next registered state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pulses_q <= CNT_ZERO;
            phase_q  <= LEN_ZERO;
            hlen_q   <= LEN_ZERO;
            llen_q   <= LEN_ZERO;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pulses_q <= pulses_d;
            phase_q  <= phase_d;
            hlen_q   <= hlen_d;
            llen_q   <= llen_d;
            out_q    <= (state_d == S_HIGH);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
